// File: rtl/axi_arbiter.sv
// axi_arbiter: two masters share one slave through simple valid/ready write
// and read requests. Each response is a single-cycle pulse. A response
// timeout makes sure a master is never left waiting forever.
//
// state | meaning
// IDLE  | no owner; choose a requesting master, prio breaks a tie
// GRANT | forward the owner's latched request and wait for the slave to accept
// BUSY  | request accepted; wait for bvalid/rvalid or for the timeout
module axi_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  input  logic [31:0] m0_awaddr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_bvalid,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  input  logic [31:0] m0_araddr,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  input  logic [31:0] m1_awaddr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_bvalid,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  input  logic [31:0] m1_araddr,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        s_wvalid,
  input  logic        s_wready,
  output logic [31:0] s_awaddr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_bvalid,
  output logic        s_arvalid,
  input  logic        s_arready,
  output logic [31:0] s_araddr,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  output logic        timeout_err,
  output logic [7:0]  timeout_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       is_read_q, is_read_d;
  logic       prio_q, prio_d;
  logic [7:0] tmr_q, tmr_d;
  logic       timeout_err_q, timeout_err_d;
  logic [7:0] timeout_cnt_q, timeout_cnt_d;

  logic        req0, req1, new_owner, new_wvalid;
  logic        own_wvalid, own_arvalid, own_valid;
  logic        in_grant, in_busy, grant_w, grant_r;
  logic        hs, resp, tmo, done;
  logic [31:0] rdata_sel;

  assign req0       = m0_wvalid | m0_arvalid;
  assign req1       = m1_wvalid | m1_arvalid;
  assign new_owner  = (req0 & req1) ? prio_q : req1;
  assign new_wvalid = new_owner ? m1_wvalid : m0_wvalid;

  assign own_wvalid  = owner_q ? m1_wvalid : m0_wvalid;
  assign own_arvalid = owner_q ? m1_arvalid : m0_arvalid;
  assign own_valid   = is_read_q ? own_arvalid : own_wvalid;

  assign in_grant = (state_q == ST_GRANT);
  assign in_busy  = (state_q == ST_BUSY);
  assign grant_w  = in_grant & ~is_read_q;
  assign grant_r  = in_grant & is_read_q;

  // The payload follows the owner at all times. Only the valids are gated,
  // so address and data reach the slave with no added latency.
  assign s_awaddr  = owner_q ? m1_awaddr : m0_awaddr;
  assign s_wdata   = owner_q ? m1_wdata : m0_wdata;
  assign s_wstrb   = owner_q ? m1_wstrb : m0_wstrb;
  assign s_araddr  = owner_q ? m1_araddr : m0_araddr;
  assign s_wvalid  = grant_w & own_wvalid;
  assign s_arvalid = grant_r & own_arvalid;

  assign m0_wready  = grant_w & ~owner_q & s_wready;
  assign m1_wready  = grant_w & owner_q & s_wready;
  assign m0_arready = grant_r & ~owner_q & s_arready;
  assign m1_arready = grant_r & owner_q & s_arready;

  assign hs   = (s_wvalid & s_wready) | (s_arvalid & s_arready);
  // Responses are only looked at in BUSY. A pulse of the wrong kind, or one
  // that arrives in any other state, is dropped.
  assign resp = in_busy & (is_read_q ? s_rvalid : s_bvalid);
  assign tmo  = in_busy & ~resp & (tmr_q == TIMEOUT);
  assign done = resp | tmo;

  assign rdata_sel = tmo ? 32'hDEAD_BEEF : s_rdata;
  assign m0_bvalid = done & ~is_read_q & ~owner_q;
  assign m1_bvalid = done & ~is_read_q & owner_q;
  assign m0_rvalid = done & is_read_q & ~owner_q;
  assign m1_rvalid = done & is_read_q & owner_q;
  assign m0_rdata  = (in_busy & ~owner_q) ? rdata_sel : 32'h0;
  assign m1_rdata  = (in_busy & owner_q) ? rdata_sel : 32'h0;

  assign timeout_err = timeout_err_q;
  assign timeout_cnt = timeout_cnt_q;

  // Next-state logic for the arbitration FSM, the timer and the timeout status.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    is_read_d     = is_read_q;
    prio_d        = prio_q;
    tmr_d         = tmr_q;
    timeout_err_d = timeout_err_q;
    timeout_cnt_d = timeout_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          owner_d   = new_owner;
          is_read_d = ~new_wvalid;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (hs) begin
          tmr_d   = 8'd0;
          state_d = ST_BUSY;
        end else if (!own_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d = ST_IDLE;
          prio_d  = ~owner_q;
          if (tmo) begin
            timeout_err_d = 1'b1;
            if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers. Asynchronous reset drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      is_read_q     <= 1'b0;
      prio_q        <= 1'b0;
      tmr_q         <= 8'd0;
      timeout_err_q <= 1'b0;
      timeout_cnt_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      is_read_q     <= is_read_d;
      prio_q        <= prio_d;
      tmr_q         <= tmr_d;
      timeout_err_q <= timeout_err_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Bench for axi_arbiter: directed vector table, hand sequences for timeout
// and reset, then random traffic checked against a transaction-level model.
module tb_axi_arbiter;
  localparam logic [7:0] TMO = 8'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_wvalid = 0, m0_arvalid = 0, m1_wvalid = 0, m1_arvalid = 0;
  logic [31:0] m0_awaddr = 0, m0_wdata = 0, m0_araddr = 0;
  logic [31:0] m1_awaddr = 0, m1_wdata = 0, m1_araddr = 0;
  logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic s_wready = 0, s_arready = 0, s_bvalid = 0, s_rvalid = 0;
  logic [31:0] s_rdata = 0;
  logic m0_wready, m0_bvalid, m0_arready, m0_rvalid;
  logic m1_wready, m1_bvalid, m1_arready, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic s_wvalid, s_arvalid;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0] s_wstrb;
  logic timeout_err;
  logic [7:0] timeout_cnt;

  axi_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_awaddr(m0_awaddr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_bvalid(m0_bvalid),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_awaddr(m1_awaddr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_bvalid(m1_bvalid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_awaddr(s_awaddr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_bvalid(s_bvalid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // in : {rst, m0_wvalid, m0_arvalid, m1_wvalid, m1_arvalid, s_wready, s_arready, s_bvalid, s_rvalid}
  // ex : {m0_wready, m0_arready, m0_bvalid, m0_rvalid, m1_wready, m1_arready, m1_bvalid, m1_rvalid, s_wvalid, s_arvalid}
  typedef struct packed {
    logic [8:0]  in;
    logic [31:0] rd;
    logic [9:0]  ex;
    logic [31:0] r0;
    logic [31:0] r1;
  } vec_t;
  vec_t tbl[$];

  typedef struct packed {
    logic [1:0]  wready, arready, bvalid, rvalid;
    logic [31:0] rdata0, rdata1;
    logic        s_wvalid, s_arvalid;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic [31:0] araddr;
    logic        err;
    logic [7:0]  cnt;
  } obs_t;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [8:0] in, input logic [31:0] rd, input logic [9:0] ex,
                     input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v.in = in; v.rd = rd; v.ex = ex; v.r0 = r0; v.r1 = r1;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [8:0] in, input logic [31:0] rd);
    {rst, m0_wvalid, m0_arvalid, m1_wvalid, m1_arvalid,
     s_wready, s_arready, s_bvalid, s_rvalid} = in;
    s_rdata = rd;
  endtask

  task automatic cyc(input logic [8:0] in, input logic [31:0] rd);
    @(posedge clk); #1;
    drive(in, rd);
    @(negedge clk);
  endtask

  function automatic logic [9:0] flags();
    return {m0_wready, m0_arready, m0_bvalid, m0_rvalid,
            m1_wready, m1_arready, m1_bvalid, m1_rvalid, s_wvalid, s_arvalid};
  endfunction

  // transaction-level reference: current grant, whether accepted, cycles waited
  bit md_act, md_acc, md_mst, md_rd, md_prio, md_err;
  int md_wait, md_cnt;

  task automatic md_reset();
    md_act = 0; md_acc = 0; md_mst = 0; md_rd = 0; md_prio = 0; md_err = 0;
    md_wait = 0; md_cnt = 0;
  endtask

  initial begin
    obs_t e, g;
    logic [1:0] wv, av;
    logic [31:0] aw[2], wd[2], ar[2];
    logic [3:0] ws[2];
    bit resp, own_busy, found;
    int n;

    m0_awaddr = 32'h0000_0010; m0_wdata = 32'h1111_2222; m0_wstrb = 4'hF;
    m1_awaddr = 32'h0000_0020; m1_araddr = 32'h0000_0024; m0_araddr = 32'h0000_0014;
    // single m0 write, then a tie that m1 must win
    add(9'b0_1000_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_1000_1000, 32'h0, 10'b1000_0000_10, 32'h0, 32'h0);
    add(9'b0_0000_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0000_0010, 32'h0, 10'b0010_0000_00, 32'h0, 32'h0);
    add(9'b0_1010_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_1010_1000, 32'h0, 10'b0000_1000_10, 32'h0, 32'h0);
    add(9'b1_0000_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    // alternating reads with a stray response in IDLE and a wrong-kind one in BUSY
    add(9'b0_0101_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0101_0100, 32'h0, 10'b0100_0000_01, 32'h0, 32'h0);
    add(9'b0_0101_0001, 32'hA5A5_0000, 10'b0001_0000_00, 32'hA5A5_0000, 32'h0);
    add(9'b0_0101_0001, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0101_0100, 32'h0, 10'b0000_0100_01, 32'h0, 32'h0);
    add(9'b0_0101_0001, 32'h5A5A_1111, 10'b0000_0001_00, 32'h0, 32'h5A5A_1111);
    add(9'b0_0101_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0101_0100, 32'h0, 10'b0100_0000_01, 32'h0, 32'h0);
    add(9'b0_0101_0010, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0101_0001, 32'h1234_5678, 10'b0001_0000_00, 32'h1234_5678, 32'h0);
    add(9'b1_0000_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    // m1 write and read together: write goes first
    add(9'b0_0011_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0011_1100, 32'h0, 10'b0000_1000_10, 32'h0, 32'h0);
    add(9'b0_0001_0101, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0001_0110, 32'h0, 10'b0000_0010_00, 32'h0, 32'h0);
    add(9'b0_0001_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0001_0100, 32'h0, 10'b0000_0100_01, 32'h0, 32'h0);
    add(9'b0_0000_0001, 32'h0BAD_F00D, 10'b0000_0001_00, 32'h0, 32'h0BAD_F00D);
    add(9'b1_0000_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    // m0 drops arvalid in GRANT; prio stays 0 so m0 wins the next tie
    add(9'b0_0100_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0100_0000, 32'h0, 10'b0000_0000_01, 32'h0, 32'h0);
    add(9'b0_0000_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0101_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);
    add(9'b0_0101_0100, 32'h0, 10'b0100_0000_01, 32'h0, 32'h0);
    add(9'b0_0101_0001, 32'h0000_0001, 10'b0001_0000_00, 32'h0000_0001, 32'h0);
    add(9'b1_0000_0000, 32'h0, 10'b0000_0000_00, 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].in, tbl[i].rd);
      chk($sformatf("row%0d", i), {flags(), m0_rdata, m1_rdata},
          {tbl[i].ex, tbl[i].r0, tbl[i].r1});
      if (i == 1) chk("s_awaddr", s_awaddr, 32'h0000_0010);
    end

    // timeout: m0 read accepted, never answered
    cyc(9'b0_0100_0000, 32'h0);
    cyc(9'b0_0100_0100, 32'h0);
    chk("tmo_accept", m0_arready, 1'b1);
    found = 0;
    n = 0;
    while (!found && n < 20) begin
      cyc(9'b0_0000_0000, 32'h0);
      if (m0_rvalid) found = 1; else n++;
    end
    chk("tmo_wait_cycles", {found, n[7:0]}, {1'b1, 8'd4});
    chk("tmo_rdata", m0_rdata, 32'hDEAD_BEEF);
    cyc(9'b0_0000_0000, 32'h0);
    chk("tmo_status", {timeout_err, timeout_cnt}, {1'b1, 8'd1});
    cyc(9'b0_0000_0001, 32'h5555_5555);
    chk("tmo_stray", {m0_rvalid, m1_rvalid, m0_rdata}, 34'h0);

    // reset while BUSY
    cyc(9'b0_0010_0000, 32'h0);
    cyc(9'b0_0010_1000, 32'h0);
    chk("rst_accept", m1_wready, 1'b1);
    @(posedge clk); #1;
    drive(9'b0_0000_0000, 32'h0);
    #1;
    rst = 1'b1; s_bvalid = 1'b1;
    #1;
    chk("rst_outputs", {flags(), timeout_err, timeout_cnt}, 19'h0);
    cyc(9'b0_0000_0010, 32'h0);
    chk("rst_late_resp", flags(), 10'h0);
    cyc(9'b0_1000_0000, 32'h0);
    cyc(9'b0_1000_1000, 32'h0);
    chk("rst_regrant", {m0_wready, s_wvalid, s_awaddr}, {2'b11, 32'h0000_0010});
    cyc(9'b1_0000_0000, 32'h0);

    // random traffic against the reference model
    md_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      m0_wvalid = ($urandom_range(0, 2) == 0);
      m0_arvalid = ($urandom_range(0, 2) == 0);
      m1_wvalid = ($urandom_range(0, 2) == 0);
      m1_arvalid = ($urandom_range(0, 2) == 0);
      m0_awaddr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom); m0_araddr = $urandom;
      m1_awaddr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom); m1_araddr = $urandom;
      s_wready = 1'($urandom_range(0, 1));
      s_arready = 1'($urandom_range(0, 1));
      s_bvalid = ($urandom_range(0, 4) == 0);
      s_rvalid = ($urandom_range(0, 4) == 0);
      s_rdata = $urandom;
      @(negedge clk);

      wv = {m1_wvalid, m0_wvalid}; av = {m1_arvalid, m0_arvalid};
      aw[0] = m0_awaddr; aw[1] = m1_awaddr; wd[0] = m0_wdata; wd[1] = m1_wdata;
      ws[0] = m0_wstrb; ws[1] = m1_wstrb; ar[0] = m0_araddr; ar[1] = m1_araddr;
      e = '0;
      resp = 0;
      if (rst) md_reset();
      own_busy = md_act && md_acc;
      if (md_act && !md_acc) begin
        if (md_rd) begin
          e.s_arvalid = av[md_mst]; e.araddr = ar[md_mst];
          e.arready[md_mst] = s_arready;
        end else begin
          e.s_wvalid = wv[md_mst]; e.awaddr = aw[md_mst];
          e.wdata = wd[md_mst]; e.wstrb = ws[md_mst];
          e.wready[md_mst] = s_wready;
        end
      end else if (own_busy) begin
        resp = md_rd ? s_rvalid : s_bvalid;
        if (resp || md_wait == int'(TMO)) begin
          if (md_rd) begin
            e.rvalid[md_mst] = 1'b1;
            if (md_mst) e.rdata1 = resp ? s_rdata : 32'hDEAD_BEEF;
            else        e.rdata0 = resp ? s_rdata : 32'hDEAD_BEEF;
          end else begin
            e.bvalid[md_mst] = 1'b1;
          end
        end
      end
      e.err = md_err; e.cnt = 8'(md_cnt);

      g.wready = {m1_wready, m0_wready}; g.arready = {m1_arready, m0_arready};
      g.bvalid = {m1_bvalid, m0_bvalid}; g.rvalid = {m1_rvalid, m0_rvalid};
      g.rdata0 = m0_rdata; g.rdata1 = m1_rdata;
      g.s_wvalid = s_wvalid; g.s_arvalid = s_arvalid;
      g.awaddr = s_awaddr; g.wdata = s_wdata; g.wstrb = s_wstrb; g.araddr = s_araddr;
      g.err = timeout_err; g.cnt = timeout_cnt;
      if (!e.s_wvalid) begin
        e.awaddr = '0; e.wdata = '0; e.wstrb = '0;
        g.awaddr = '0; g.wdata = '0; g.wstrb = '0;
      end
      if (!e.s_arvalid) begin e.araddr = '0; g.araddr = '0; end
      if (own_busy && !md_mst && !e.rvalid[0]) begin e.rdata0 = '0; g.rdata0 = '0; end
      if (own_busy && md_mst && !e.rvalid[1]) begin e.rdata1 = '0; g.rdata1 = '0; end
      chk($sformatf("rand%0d", c), 256'(g), 256'(e));

      if (!rst) begin
        if (!md_act) begin
          if ((wv | av) != 2'b00) begin
            md_mst = ((wv[0] | av[0]) && (wv[1] | av[1])) ? md_prio : (wv[1] | av[1]);
            md_rd = !wv[md_mst];
            md_act = 1; md_acc = 0;
          end
        end else if (!md_acc) begin
          if (md_rd ? (av[md_mst] && s_arready) : (wv[md_mst] && s_wready)) begin
            md_acc = 1; md_wait = 0;
          end else if (!(md_rd ? av[md_mst] : wv[md_mst])) begin
            md_act = 0;
          end
        end else if (resp) begin
          md_act = 0; md_acc = 0; md_prio = !md_mst;
        end else if (md_wait == int'(TMO)) begin
          md_act = 0; md_acc = 0; md_prio = !md_mst; md_err = 1;
          if (md_cnt < 255) md_cnt++;
        end else begin
          md_wait++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
